// File: rtl/data_mem_responder_pkg.sv
// Shared types for the data-memory responder.
//   rv32i_word    : 32-bit machine word
//   resp_state_t  : responder FSM states (IDLE, WAIT, RESP)
//   req_op_t      : captured request kind
//   mem_req_t     : one captured request (op, word index, write data, lane mask,
//                   out-of-range flag, read&write conflict flag)
//   in_window()   : byte-address window test used for the range check
package mem_resp_types;

  typedef logic [31:0] rv32i_word;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } resp_state_t;

  typedef enum logic {
    OP_READ,
    OP_WRITE
  } req_op_t;

  // idx holds the full word offset from the base; the top truncates it to
  // the array address width when driving the array.
  typedef struct packed {
    req_op_t   op;
    rv32i_word idx;
    rv32i_word wdata;
    logic [3:0] be;
    logic      oor;
    logic      conflict;
  } mem_req_t;

  // Unsigned wrap makes addresses below base look huge, so one compare
  // covers both ends of the window.
  function automatic logic in_window(input rv32i_word addr, input rv32i_word base,
                                     input rv32i_word span);
    return (addr - base) < span;
  endfunction

endpackage

// File: rtl/data_mem_responder_dmem_array.sv
// dmem_array: WORDS x 32-bit storage, split into four byte lanes so each lane
// is a plain synchronous-write / synchronous-read memory.
//   clk     in  clock, rising edge
//   i_we    in  write strobe (one cycle)
//   i_be    in  per-lane write mask
//   i_addr  in  word address
//   i_wdata in  write data
//   i_re    in  read strobe; o_rdata updates on the next edge
//   o_rdata out registered read data (held between reads, not reset)
module dmem_array #(
  parameter int WORDS = 256,
  parameter int AW    = $clog2(WORDS)
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic [3:0]    i_be,
  input  logic [AW-1:0] i_addr,
  input  logic [31:0]   i_wdata,
  input  logic          i_re,
  output logic [31:0]   o_rdata
);

  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    logic [7:0] r_lane [WORDS];
    logic [7:0] r_q;

    always_ff @(posedge clk) begin
      if (i_we && i_be[gi]) begin
        r_lane[i_addr] <= i_wdata[8*gi +: 8];
      end
      if (i_re) begin
        r_q <= r_lane[i_addr];
      end
    end

    assign o_rdata[8*gi +: 8] = r_q;
  end

endmodule

// File: rtl/data_mem_responder.sv
// data_mem_responder: memory side of the CPU data port. Accepts one request at
// a time, waits LATENCY cycles, then pulses mem_resp for one cycle. Writes are
// merged per byte lane; reads return the aligned word.
//   clk             in   clock, rising edge
//   rst             in   asynchronous reset, active low
//   mem_read        in   read request, held until mem_resp
//   mem_write       in   write request, held until mem_resp
//   mem_address     in   byte address, bits [1:0] ignored
//   mem_wdata       in   lane-shifted write data
//   mem_byte_enable in   write lane mask
//   mem_rdata       out  read data, non-zero only in the mem_resp cycle of a read
//   mem_resp        out  one-cycle completion pulse
//   mem_err         out  sticky error (out of range, or read and write together)
module data_mem_responder
  import mem_resp_types::*;
#(
  parameter int        ADDR_WORDS = 256,
  parameter int        LATENCY    = 2,
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [31:0] mem_address,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_byte_enable,
  output logic [31:0] mem_rdata,
  output logic        mem_resp,
  output logic        mem_err
);

  localparam int        AW       = $clog2(ADDR_WORDS);
  localparam rv32i_word SPAN     = rv32i_word'(ADDR_WORDS) << 2;
  localparam logic [3:0] LAT_LOAD = (LATENCY == 0) ? 4'd0 : 4'(LATENCY - 1);

  resp_state_t r_state;
  logic [3:0]  r_cnt;
  mem_req_t    r_req;
  logic        r_resp;
  logic        r_err;
  logic        r_rd_valid;

  mem_req_t    w_in_req;
  mem_req_t    w_cur_req;
  logic        w_req_seen;
  logic        w_fire;
  logic        w_arr_we;
  logic        w_arr_re;
  logic [31:0] w_arr_q;

  assign w_req_seen = mem_read | mem_write;

  // Decode the live inputs into a request; a simultaneous read and write is
  // carried out as a write and flagged.
  always_comb begin
    w_in_req          = '0;
    w_in_req.op       = mem_write ? OP_WRITE : OP_READ;
    w_in_req.idx      = (mem_address - BASE_ADDR) >> 2;
    w_in_req.wdata    = mem_wdata;
    w_in_req.be       = mem_byte_enable;
    w_in_req.oor      = !in_window(mem_address, BASE_ADDR, SPAN);
    w_in_req.conflict = mem_read & mem_write;
  end

  // With zero latency the array is accessed straight from IDLE, before the
  // request registers have been loaded, so the live decode is used there.
  assign w_cur_req = (r_state == IDLE) ? w_in_req : r_req;

  // w_fire marks the edge that enters RESP: array access, resp and error
  // all take effect on that edge.
  assign w_fire = ((r_state == IDLE) && w_req_seen && (LATENCY == 0)) ||
                  ((r_state == WAIT) && (r_cnt == 4'd0));

  assign w_arr_we = w_fire && (w_cur_req.op == OP_WRITE) && !w_cur_req.oor;
  assign w_arr_re = w_fire && (w_cur_req.op == OP_READ)  && !w_cur_req.oor;

  dmem_array #(
    .WORDS (ADDR_WORDS),
    .AW    (AW)
  ) u_array (
    .clk     (clk),
    .i_we    (w_arr_we),
    .i_be    (w_cur_req.be),
    .i_addr  (AW'(w_cur_req.idx)),
    .i_wdata (w_cur_req.wdata),
    .i_re    (w_arr_re),
    .o_rdata (w_arr_q)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= IDLE;
      r_cnt      <= 4'd0;
      r_req      <= '0;
      r_resp     <= 1'b0;
      r_err      <= 1'b0;
      r_rd_valid <= 1'b0;
    end else begin
      r_resp     <= w_fire;
      r_rd_valid <= w_arr_re;
      if (w_fire && (w_cur_req.oor || w_cur_req.conflict)) begin
        r_err <= 1'b1;
      end
      case (r_state)
        IDLE: begin
          if (w_req_seen) begin
            r_req <= w_in_req;
            if (LATENCY == 0) begin
              r_state <= RESP;
            end else begin
              r_state <= WAIT;
              r_cnt   <= LAT_LOAD;
            end
          end
        end
        WAIT: begin
          if (r_cnt == 4'd0) begin
            r_state <= RESP;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        RESP:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  // The array output register is not reset; the valid flag keeps stale or
  // out-of-range data off the bus.
  assign mem_rdata = r_rd_valid ? w_arr_q : 32'h0;
  assign mem_resp  = r_resp;
  assign mem_err   = r_err;

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: two instances share clock and reset.
//   dut 0: ADDR_WORDS=256, LATENCY=2, BASE_ADDR=0x1000
//   dut 1: ADDR_WORDS=16,  LATENCY=0, BASE_ADDR=0x0
// Each request pushes its expected rdata/err/response cycle; the per-cycle
// monitor pops and compares when mem_resp is seen.
module tb_data_mem_responder;

  localparam logic [31:0] B0 = 32'h0000_1000;

  typedef struct {
    logic [31:0] rdata;
    bit          err;
    int unsigned cyc;
    string       tag;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        rd_s    [2];
  logic        wr_s    [2];
  logic [31:0] addr_s  [2];
  logic [31:0] wdata_s [2];
  logic [3:0]  be_s    [2];
  logic [31:0] rdata_s [2];
  logic        resp_s  [2];
  logic        err_s   [2];

  int unsigned cyc = 0;
  int          n_checks = 0;
  int          n_fail = 0;
  int          act = 0;
  exp_t        sb_q [$];
  logic [31:0] mdl_mem [int];
  bit          model_err [2];
  bit          err_shown [2];
  bit          prev_resp [2];

  for (genvar gi = 0; gi < 2; gi++) begin : g_dut
    data_mem_responder #(
      .ADDR_WORDS ((gi == 0) ? 256 : 16),
      .LATENCY    ((gi == 0) ? 2 : 0),
      .BASE_ADDR  ((gi == 0) ? B0 : 32'h0)
    ) u_dut (
      .clk             (clk),
      .rst             (rst),
      .mem_read        (rd_s[gi]),
      .mem_write       (wr_s[gi]),
      .mem_address     (addr_s[gi]),
      .mem_wdata       (wdata_s[gi]),
      .mem_byte_enable (be_s[gi]),
      .mem_rdata       (rdata_s[gi]),
      .mem_resp        (resp_s[gi]),
      .mem_err         (err_s[gi])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] base_of(input int d);
    return (d == 0) ? B0 : 32'h0;
  endfunction
  function automatic int unsigned words_of(input int d);
    return (d == 0) ? 256 : 16;
  endfunction
  function automatic int unsigned lat_of(input int d);
    return (d == 0) ? 2 : 0;
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock of monitoring, sampled on the falling edge.
  task automatic tick();
    exp_t e;
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      if (resp_s[d]) begin
        check_eq("no_dbl_resp", 32'(prev_resp[d]), 32'h0);
        if (d == act && sb_q.size() > 0) begin
          e = sb_q.pop_front();
          check_eq({e.tag, "_rdata"}, rdata_s[d], e.rdata);
          check_eq({e.tag, "_err"}, 32'(err_s[d]), 32'(e.err));
          check_eq({e.tag, "_cyc"}, cyc, e.cyc);
          err_shown[d] = e.err;
        end else begin
          check_eq("spurious_resp", 32'(resp_s[d]), 32'h0);
        end
      end else begin
        check_eq("idle_rdata", rdata_s[d], 32'h0);
        check_eq("idle_err", 32'(err_s[d]), 32'(err_shown[d]));
      end
      prev_resp[d] = resp_s[d];
    end
  endtask

  // Called just after a rising edge; drives the request, waits for its
  // response and drops the request after the response cycle.
  task automatic do_req(input int d, input bit rd, input bit wr, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [3:0] be, input string tag);
    exp_t        e;
    logic [31:0] off;
    bit          inr;
    int          key;
    bit          got;
    off     = addr - base_of(d);
    inr     = (off < (words_of(d) * 4));
    key     = d * 4096 + int'(off >> 2);
    e.rdata = 32'h0;
    if (wr) begin
      if (inr) begin
        for (int i = 0; i < 4; i++) begin
          if (be[i]) mdl_mem[key][8*i +: 8] = wdata[8*i +: 8];
        end
      end
    end else if (inr) begin
      e.rdata = mdl_mem[key];
    end
    if (!inr || (rd && wr)) model_err[d] = 1'b1;
    e.err = model_err[d];
    e.cyc = cyc + 1 + lat_of(d);
    e.tag = tag;
    sb_q.push_back(e);
    act        = d;
    rd_s[d]    = rd;
    wr_s[d]    = wr;
    addr_s[d]  = addr;
    wdata_s[d] = wdata;
    be_s[d]    = be;
    got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      tick();
      got = (sb_q.size() == 0);
    end
    check_eq({tag, "_done"}, 32'(got), 32'h1);
    if (!got) sb_q.delete();
    $display("txn %-14s dut%0d rd=%0d wr=%0d addr=%h wdata=%h be=%b exp_rdata=%h exp_err=%0d",
             tag, d, rd, wr, addr, wdata, be, e.rdata, e.err);
    @(posedge clk);
    #1;
    rd_s[d] = 1'b0;
    wr_s[d] = 1'b0;
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      rd_s[d] = 1'b0; wr_s[d] = 1'b0; addr_s[d] = 32'h0;
      wdata_s[d] = 32'h0; be_s[d] = 4'h0;
      model_err[d] = 1'b0; err_shown[d] = 1'b0; prev_resp[d] = 1'b0;
    end
    rst = 1'b1;
    #1 rst = 1'b0;
    #3;
    for (int d = 0; d < 2; d++) begin
      check_eq("rst_resp", 32'(resp_s[d]), 32'h0);
      check_eq("rst_rdata", rdata_s[d], 32'h0);
      check_eq("rst_err", 32'(err_s[d]), 32'h0);
    end
    repeat (2) tick();
    @(posedge clk);
    #1 rst = 1'b1;

    // Write then read back, back-to-back, latency 2
    do_req(0, 0, 1, B0 + 32'h10, 32'hDEAD_BEEF, 4'hF, "t1_wr");
    do_req(0, 1, 0, B0 + 32'h10, 32'h0, 4'h0, "t1_rd");

    // Byte-lane merge, no-op write, ignored low address bits
    do_req(0, 0, 1, B0 + 32'h20, 32'h1122_3344, 4'hF, "t2_wr");
    do_req(0, 0, 1, B0 + 32'h20, 32'h00AB_0000, 4'b0100, "t2_merge");
    do_req(0, 1, 0, B0 + 32'h20, 32'h0, 4'h0, "t2_rd");
    do_req(0, 0, 1, B0 + 32'h20, 32'hFFFF_FFFF, 4'b0000, "t2_noop");
    do_req(0, 1, 0, B0 + 32'h22, 32'h0, 4'h0, "t2_rd_lowbits");

    // Range boundaries
    do_req(0, 0, 1, B0, 32'h0102_0304, 4'hF, "t4_wr0");
    do_req(0, 0, 1, B0 + 32'h3FC, 32'hA5A5_5A5A, 4'hF, "t4_wr_last");
    do_req(0, 1, 0, B0 + 32'h3FC, 32'h0, 4'h0, "t4_rd_last");
    do_req(0, 1, 0, B0 + 32'h400, 32'h0, 4'h0, "t4_oor_hi");
    do_req(0, 1, 0, B0 - 32'h4, 32'h0, 4'h0, "t4_oor_lo");
    do_req(0, 0, 1, B0 + 32'h400, 32'hBADB_AD00, 4'hF, "t4_oor_wr");
    do_req(0, 1, 0, B0, 32'h0, 4'h0, "t4_rd0");
    do_req(0, 0, 1, B0 + 32'h30, 32'h0F0F_0F0F, 4'hF, "t4_wr_after");
    do_req(0, 1, 0, B0 + 32'h30, 32'h0, 4'h0, "t4_rd_after");

    // Reset while the request sits in WAIT: no response may follow
    act       = 0;
    rd_s[0]   = 1'b1;
    addr_s[0] = B0 + 32'h10;
    tick();
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int d = 0; d < 2; d++) begin
      model_err[d] = 1'b0;
      err_shown[d] = 1'b0;
    end
    tick();
    @(posedge clk);
    #1;
    rst     = 1'b1;
    rd_s[0] = 1'b0;
    repeat (8) tick();
    @(posedge clk);
    #1;
    do_req(0, 1, 0, B0 + 32'h10, 32'h0, 4'h0, "t5_rd_post_rst");
    do_req(0, 1, 0, B0 + 32'h3FC, 32'h0, 4'h0, "t5_rd_last");

    // Zero-latency instance
    do_req(1, 0, 1, 32'h8, 32'hCAFE_F00D, 4'hF, "t6_wr");
    do_req(1, 1, 0, 32'h8, 32'h0, 4'h0, "t6_rd");
    do_req(1, 1, 1, 32'hC, 32'h1234_5678, 4'hF, "t6_rdwr");
    do_req(1, 1, 0, 32'hC, 32'h0, 4'h0, "t6_rd_rdwr");
    do_req(1, 1, 0, 32'h40, 32'h0, 4'h0, "t6_oor");
    do_req(1, 1, 0, 32'h8, 32'h0, 4'h0, "t6_rd_again");
    repeat (3) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
